// File: rtl/lp_pkg.sv
// Shared LP-engine types and default widths.
// Pulled in by the tableau column extractor and its stream FIFOs.
package lp_pkg;

  localparam int DATAW      = 32;
  localparam int NUM_ROWS_W = 16;
  localparam int NUM_COLS_W = 16;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    ERR_DONE
  } extract_state_t;

endpackage

// File: rtl/axi_stream_port.sv
// Minimal AXI-stream bundle: data, valid, ready.
// Modport in = sink side, out = source side.
interface axi_stream_port #(
  parameter int W = 32
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport in  (input data, input valid, output ready);
  modport out (output data, output valid, input ready);

endinterface

// File: rtl/lp_stream_fifo.sv
// Small sync FIFO, async active-high reset flushes it.
// Ports: push/push_data in, pop in, head/full/empty out.
module lp_stream_fifo #(
  parameter int DATAW      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic [DATAW-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [DATAW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/extract_ratio_cols.sv
// Splits a row-major tableau pass into per-row pivot and RHS streams.
// In: start/config, axi_tableau. Out: axi_pivotcol, axi_rightcol, busy/done/err.
module extract_ratio_cols
  import lp_pkg::*;
#(
  parameter int DATAW      = lp_pkg::DATAW,
  parameter int NUM_ROWS_W = lp_pkg::NUM_ROWS_W,
  parameter int NUM_COLS_W = lp_pkg::NUM_COLS_W,
  parameter int FIFO_DEPTH = lp_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_ROWS_W-1:0] num_rows,
  input  logic [NUM_COLS_W-1:0] num_cols,
  input  logic [NUM_COLS_W-1:0] pivot_col,
  axi_stream_port.in            axi_tableau,
  axi_stream_port.out           axi_rightcol,
  axi_stream_port.out           axi_pivotcol,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  extract_state_t state;

  logic [NUM_ROWS_W-1:0] row;
  logic [NUM_ROWS_W-1:0] rows_q;
  logic [NUM_COLS_W-1:0] col;
  logic [NUM_COLS_W-1:0] cols_q;
  logic [NUM_COLS_W-1:0] pcol_q;

  logic p_full, p_empty;
  logic r_full, r_empty;
  logic hs, col_last, row_last;
  logic p_push, r_push;
  logic p_pop, r_pop;

  // Ready depends only on state and registered FIFO counts.
  assign axi_tableau.ready = (state == RUN) && !p_full && !r_full;

  assign hs       = axi_tableau.valid && axi_tableau.ready;
  assign col_last = (col == cols_q);
  assign row_last = (row == rows_q);
  assign p_push   = hs && (col == pcol_q);
  assign r_push   = hs && col_last;

  assign axi_pivotcol.valid = !p_empty;
  assign axi_rightcol.valid = !r_empty;
  assign p_pop = axi_pivotcol.valid && axi_pivotcol.ready;
  assign r_pop = axi_rightcol.valid && axi_rightcol.ready;

  lp_stream_fifo #(
    .DATAW      (DATAW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_pivot_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (p_push),
    .push_data (axi_tableau.data),
    .pop       (p_pop),
    .head      (axi_pivotcol.data),
    .full      (p_full),
    .empty     (p_empty)
  );

  lp_stream_fifo #(
    .DATAW      (DATAW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_right_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_push),
    .push_data (axi_tableau.data),
    .pop       (r_pop),
    .head      (axi_rightcol.data),
    .full      (r_full),
    .empty     (r_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      rows_q <= '0;
      cols_q <= '0;
      pcol_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rows_q <= num_rows;
            cols_q <= num_cols;
            pcol_q <= pivot_col;
            row    <= '0;
            col    <= '0;
            if (pivot_col >= num_cols) begin
              state <= ERR_DONE;
              err   <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              err   <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            if (col_last) begin
              col <= '0;
              if (row_last) state <= DRAIN;
              else          row <= row + NUM_ROWS_W'(1);
            end else begin
              col <= col + NUM_COLS_W'(1);
            end
          end
        end
        DRAIN: begin
          if (p_empty && r_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:     state <= IDLE;
        ERR_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extract_ratio_cols.sv
// Directed bench for extract_ratio_cols.
// Scoreboard derives expected beats from the element numbering.
module tb_extract_ratio_cols;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_rows;
  logic [15:0] num_cols;
  logic [15:0] pivot_col;
  logic        busy, done, err;

  axi_stream_port #(.W(32)) tab ();
  axi_stream_port #(.W(32)) rc ();
  axi_stream_port #(.W(32)) pv ();

  extract_ratio_cols dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_rows     (num_rows),
    .num_cols     (num_cols),
    .pivot_col    (pivot_col),
    .axi_tableau  (tab),
    .axi_rightcol (rc),
    .axi_pivotcol (pv),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_pop = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int in_stall = 0;
  int rc_stall = 0;
  int pc_stall = 0;
  bit rnd_mode = 0;
  logic [31:0] pq[$];
  logic [31:0] rq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output readies change just after the edge.
  initial begin
    pv.ready = 1'b1;
    rc.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pc_stall > 0) begin
        pv.ready = 1'b0;
        pc_stall--;
      end else begin
        pv.ready = rnd_mode ? 1'($urandom % 2) : 1'b1;
      end
      if (rc_stall > 0) begin
        rc.ready = 1'b0;
        rc_stall--;
      end else begin
        rc.ready = rnd_mode ? 1'($urandom % 2) : 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (pv.valid && pv.ready) begin
      pq.push_back(pv.data);
      last_pop = cyc;
    end
    if (rc.valid && rc.ready) begin
      rq.push_back(rc.data);
      last_pop = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && tab.valid && !tab.ready) in_stall++;
  end

  task automatic do_start(input int nr, input int nc, input int pc);
    @(posedge clk);
    #1;
    num_rows  = 16'(nr);
    num_cols  = 16'(nc);
    pivot_col = 16'(pc);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    num_rows  = 16'd0;
    num_cols  = 16'd9;
    pivot_col = 16'd5;
  endtask

  task automatic drive_pass(input int nr, input int nc, input int base,
                            input bit rnd, input int abort_at,
                            input int start_at);
    int total;
    int idx;
    int guard;
    bit fired;
    total = (nr + 1) * (nc + 1);
    idx   = 0;
    guard = 0;
    fired = 0;
    while (idx < total && idx != abort_at && guard < 5000) begin
      @(posedge clk);
      #1;
      tab.valid = rnd ? 1'($urandom % 2) : 1'b1;
      tab.data  = 32'(base + idx);
      if (idx == start_at && !fired) begin
        start     = 1'b1;
        num_rows  = 16'd1;
        num_cols  = 16'd2;
        pivot_col = 16'd0;
        fired     = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (tab.valid && tab.ready) idx++;
      guard++;
    end
    @(posedge clk);
    #1;
    tab.valid = 1'b0;
    start     = 1'b0;
    chk("drive_timeout", 32'(idx == total || idx == abort_at), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(tag, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input string tag, input int nr, input int nc,
                              input int pc, input int base);
    chk({tag, "_pv_cnt"}, 32'(pq.size()), 32'(nr + 1));
    chk({tag, "_rc_cnt"}, 32'(rq.size()), 32'(nr + 1));
    for (int r = 0; r <= nr; r++) begin
      if (r < pq.size())
        chk({tag, "_pv"}, pq[r], 32'(base + r * (nc + 1) + pc));
      if (r < rq.size())
        chk({tag, "_rc"}, rq[r], 32'(base + r * (nc + 1) + nc));
    end
  endtask

  int d0;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    num_rows  = '0;
    num_cols  = '0;
    pivot_col = '0;
    tab.valid = 1'b0;
    tab.data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tready", 32'(tab.ready), 32'd0);
    chk("rst_pvalid", 32'(pv.valid), 32'd0);
    chk("rst_rvalid", 32'(rc.valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: basic pass, everything ready
    pq.delete(); rq.delete();
    do_start(2, 3, 1);
    drive_pass(2, 3, 0, 0, -1, -1);
    wait_done("t1_done");
    chk("t1_done_lat", 32'(done_cyc - last_pop), 32'd2);
    check_stream("t1", 2, 3, 1, 0);

    // 2: right output stalled, input must back-pressure
    pq.delete(); rq.delete();
    in_stall = 0;
    rc_stall = 30;
    do_start(5, 3, 1);
    drive_pass(5, 3, 200, 0, -1, -1);
    wait_done("t2_done");
    chk("t2_inready_drop", 32'(in_stall != 0), 32'd1);
    check_stream("t2", 5, 3, 1, 200);

    // 3: bad pivot column
    tab.valid = 1'b1;
    tab.data  = 32'hdead;
    do_start(2, 3, 3);
    @(negedge clk);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_tready", 32'(tab.ready), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t3_done_pulse", 32'(done), 32'd0);
    chk("t3_err_sticky", 32'(err), 32'd1);
    chk("t3_tready2", 32'(tab.ready), 32'd0);
    tab.valid = 1'b0;
    pq.delete(); rq.delete();
    do_start(1, 1, 0);
    @(negedge clk);
    chk("t3_err_clr", 32'(err), 32'd0);
    drive_pass(1, 1, 300, 0, -1, -1);
    wait_done("t3_done2");
    check_stream("t3", 1, 1, 0, 300);

    // 5: reset mid-pass with outputs held off
    pc_stall = 100;
    rc_stall = 100;
    do_start(3, 3, 2);
    drive_pass(3, 3, 500, 0, 5, -1);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_pvalid", 32'(pv.valid), 32'd0);
    chk("t5_rst_rvalid", 32'(rc.valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    pc_stall = 0;
    rc_stall = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_post_pvalid", 32'(pv.valid), 32'd0);
    chk("t5_post_rvalid", 32'(rc.valid), 32'd0);
    pq.delete(); rq.delete();
    do_start(2, 2, 0);
    drive_pass(2, 2, 700, 0, -1, -1);
    wait_done("t5_done");
    chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_stream("t5", 2, 2, 0, 700);

    // 6: start pulse during RUN is ignored
    pq.delete(); rq.delete();
    do_start(3, 4, 2);
    drive_pass(3, 4, 900, 0, -1, 7);
    wait_done("t6_done");
    chk("t6_err", 32'(err), 32'd0);
    check_stream("t6", 3, 4, 2, 900);

    // 4: random valid/ready on all streams
    pq.delete(); rq.delete();
    rnd_mode = 1;
    do_start(15, 7, 0);
    drive_pass(15, 7, 32'h2000, 1, -1, -1);
    wait_done("t4_done");
    rnd_mode = 0;
    check_stream("t4", 15, 7, 0, 32'h2000);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
